// File: rtl/ban_shift_ctrl.sv
// Serialises a parallel configuration word onto a flop chain, LSB first, one SE pulse per bit.
// Optional even-parity tail bit is built in when BAN_SHIFT_PARITY_EN is defined.
module ban_shift_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 6
) (
    input  logic             CKN,
    input  logic             R,
    input  logic             LD,
    input  logic [WIDTH-1:0] DIN,
    output logic             RDY,
    output logic             SO,
    output logic             SE,
    output logic             BUSY,
    output logic             DONE
);

`ifdef BAN_SHIFT_PARITY_EN
    localparam int NBITS = WIDTH + 1;
`else
    localparam int NBITS = WIDTH;
`endif

    localparam logic [1:0] IDLE    = 2'b00;
    localparam logic [1:0] SHIFT   = 2'b01;
    localparam logic [1:0] FIN     = 2'b10;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NBITS - 1);

    generate
        if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
            $error("ban_shift_ctrl: WIDTH must be in 2..32");
        end
        if (CNT_W < $clog2(WIDTH + 2)) begin : g_bad_cnt_w
            $error("ban_shift_ctrl: CNT_W too narrow for WIDTH");
        end
    endgenerate

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [NBITS-1:0] sr;
    logic [NBITS-1:0] load_word;
    logic [CNT_W-1:0] cnt;
    logic             accept;

`ifdef BAN_SHIFT_PARITY_EN
    assign load_word = {^DIN, DIN};
`else
    assign load_word = DIN;
`endif

    // LD outside IDLE is simply dropped; there is no pending-request storage.
    assign accept = (state == IDLE) && LD;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(negedge CKN) begin
        if (R) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(negedge CKN) begin
        if (R) begin
            sr  <= '0;
            cnt <= '0;
        end else if (accept) begin
            sr  <= load_word;
            cnt <= '0;
        end else if (state == SHIFT) begin
            sr  <= sr >> 1;
            cnt <= cnt + 1'b1;
        end
    end

    // NOTE: the default assignment up front keeps this combinational block latch-free.
    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE:    state_nxt = LD ? SHIFT : IDLE;
            SHIFT:   state_nxt = (cnt == LAST_CNT) ? FIN : SHIFT;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The reserved encoding drives every output low so nothing is clocked or accepted.
    always_comb begin
        RDY  = 1'b0;
        SO   = 1'b0;
        SE   = 1'b0;
        BUSY = 1'b0;
        DONE = 1'b0;
        case (state)
            IDLE:  RDY = 1'b1;
            SHIFT: begin
                SE   = 1'b1;
                BUSY = 1'b1;
                SO   = sr[0];
            end
            FIN:   DONE = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ban_shift_ctrl.sv
// Self-checking bench for ban_shift_ctrl: queue-based reference model plus directed literal checks.
// Honours BAN_SHIFT_PARITY_EN the same way the design does.
module tb_ban_shift_ctrl;

    localparam int WIDTH = 8;
    localparam int CNT_W = 6;
`ifdef BAN_SHIFT_PARITY_EN
    localparam int NBITS = WIDTH + 1;
    localparam logic [NBITS-1:0] A5_BITS = 9'h0A5;
    localparam logic [NBITS-1:0] B07_BITS = 9'h107;
    localparam logic [NBITS-1:0] FF_BITS = 9'h0FF;
    localparam int DONE_CYC = 11;
`else
    localparam int NBITS = WIDTH;
    localparam logic [NBITS-1:0] A5_BITS = 8'hA5;
    localparam logic [NBITS-1:0] B07_BITS = 8'h07;
    localparam logic [NBITS-1:0] FF_BITS = 8'hFF;
    localparam int DONE_CYC = 10;
`endif

    logic             CKN = 1'b1;
    logic             R   = 1'b1;
    logic             LD  = 1'b0;
    logic [WIDTH-1:0] DIN = '0;
    logic             RDY, SO, SE, BUSY, DONE;

    int errors = 0;
    int checks = 0;

    ban_shift_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .CKN (CKN),
        .R   (R),
        .LD  (LD),
        .DIN (DIN),
        .RDY (RDY),
        .SO  (SO),
        .SE  (SE),
        .BUSY(BUSY),
        .DONE(DONE)
    );

    always #5 CKN = ~CKN;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: bits still to be shifted, plus a flag for the completion cycle.
    bit m_q[$];
    bit m_fin = 1'b0;
    bit chk_en = 1'b1;

    always @(negedge CKN) begin
        if (R) begin
            m_q.delete();
            m_fin = 1'b0;
        end else if (m_fin) begin
            m_fin = 1'b0;
        end else if (m_q.size() != 0) begin
            void'(m_q.pop_front());
            if (m_q.size() == 0) m_fin = 1'b1;
        end else if (LD) begin
            for (int i = 0; i < WIDTH; i++) m_q.push_back(DIN[i]);
`ifdef BAN_SHIFT_PARITY_EN
            m_q.push_back(^DIN);
`endif
        end
    end

    bit exp_shift, exp_idle, exp_so;

    always @(posedge CKN) begin
        if (chk_en) begin
            exp_shift = (m_q.size() != 0);
            exp_idle  = !exp_shift && !m_fin;
            exp_so    = exp_shift ? m_q[0] : 1'b0;
            check("rdy",  32'(RDY),  32'(exp_idle));
            check("se",   32'(SE),   32'(exp_shift));
            check("busy", 32'(BUSY), 32'(exp_shift));
            check("so",   32'(SO),   32'(exp_so));
            check("done", 32'(DONE), 32'(m_fin));
        end
    end

    task automatic cyc();
        @(posedge CKN);
        #1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!RDY && n < 4 * NBITS) begin
            cyc();
            n++;
        end
        check("idle_timeout", 32'(RDY), 32'd1);
    endtask

    // Drives one LD pulse from IDLE and records the serial stream and the DONE cycle index.
    task automatic run_xfer(input logic [WIDTH-1:0] d, output logic [NBITS-1:0] seq,
                            output int nse, output int done_cyc);
        int n;
        seq = '0;
        nse = 0;
        done_cyc = 0;
        DIN = d;
        LD  = 1'b1;
        cyc();
        LD  = 1'b0;
        DIN = WIDTH'($urandom);
        n = 1;
        while (n <= 4 * NBITS) begin
            if (SE) begin
                if (nse < NBITS) seq[nse] = SO;
                nse++;
            end
            if (DONE) begin
                done_cyc = n + 1;
                break;
            end
            cyc();
            n++;
        end
        cyc();
    endtask

    logic [NBITS-1:0] seq;
    int nse, done_cyc;
    int rise[$];
    logic prev_se;

    initial begin
        // Reset held two cycles with LD asserted: nothing may be accepted.
        R  = 1'b1;
        LD = 1'b1;
        DIN = WIDTH'($urandom);
        cyc();
        cyc();
        check("rst_rdy",  32'(RDY),  32'd1);
        check("rst_se",   32'(SE),   32'd0);
        check("rst_so",   32'(SO),   32'd0);
        check("rst_busy", 32'(BUSY), 32'd0);
        check("rst_done", 32'(DONE), 32'd0);
        R  = 1'b0;
        LD = 1'b0;
        cyc();

        run_xfer(8'hA5, seq, nse, done_cyc);
        check("a5_stream",   32'(seq), 32'(A5_BITS));
        check("a5_se_count", 32'(nse), 32'(NBITS));
        check("a5_done_cyc", 32'(done_cyc), 32'(DONE_CYC));

        run_xfer(8'h07, seq, nse, done_cyc);
        check("h07_stream",   32'(seq), 32'(B07_BITS));
        check("h07_last_bit", 32'(seq[NBITS-1]), 32'(B07_BITS[NBITS-1]));
        check("h07_se_count", 32'(nse), 32'(NBITS));
        check("h07_done_cyc", 32'(done_cyc), 32'(DONE_CYC));

        // LD held high with DIN churning: accepts must be exactly NBITS+2 apart.
        prev_se = 1'b0;
        LD = 1'b1;
        for (int c = 0; c < 3 * (NBITS + 2) + 1; c++) begin
            DIN = WIDTH'($urandom);
            cyc();
            if (SE && !prev_se) rise.push_back(c);
            prev_se = SE;
        end
        LD = 1'b0;
        check("lockout_accepts", 32'(rise.size()), 32'd4);
        for (int i = 1; i < rise.size(); i++)
            check("lockout_spacing", 32'(rise[i] - rise[i-1]), 32'(NBITS + 2));
        wait_idle();
        cyc();

        // Reset during the 4th SE cycle aborts without DONE.
        DIN = WIDTH'($urandom);
        LD  = 1'b1;
        cyc();
        LD  = 1'b0;
        repeat (3) cyc();
        check("abort_in_shift", 32'(SE), 32'd1);
        R = 1'b1;
        cyc();
        R = 1'b0;
        check("abort_rdy",  32'(RDY),  32'd1);
        check("abort_se",   32'(SE),   32'd0);
        check("abort_done", 32'(DONE), 32'd0);
        repeat (NBITS + 3) begin
            cyc();
            check("abort_no_done", 32'(DONE), 32'd0);
        end
        run_xfer(8'hFF, seq, nse, done_cyc);
        check("ff_stream",   32'(seq), 32'(FF_BITS));
        check("ff_se_count", 32'(nse), 32'(NBITS));

        // Reserved state encoding must recover to IDLE on the next edge.
        chk_en = 1'b0;
        force dut.state = 2'b11;
        #1;
        release dut.state;
        @(negedge CKN);
        #1;
        check("illegal_rdy",  32'(RDY),  32'd1);
        check("illegal_se",   32'(SE),   32'd0);
        check("illegal_done", 32'(DONE), 32'd0);
        check("illegal_busy", 32'(BUSY), 32'd0);
        chk_en = 1'b1;
        cyc();

        // Random traffic with occasional resets, checked cycle by cycle against the model.
        for (int c = 0; c < 600; c++) begin
            R   = ($urandom_range(0, 59) == 0);
            LD  = ($urandom_range(0, 3) == 0);
            DIN = WIDTH'($urandom);
            cyc();
        end
        R  = 1'b0;
        LD = 1'b0;
        wait_idle();
        repeat (2) cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ban_shift_ctrl.md
BAN_SHIFT_CTRL -- requirements
Module: ban_shift_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the number of bits in the configuration word (legal range 2..32).
REQ-002 The block SHALL have parameter CNT_W, default 6, giving the width of the internal bit counter; it must be at least clog2(WIDTH+2).
REQ-003 The block SHALL have port CKN, input, 1 bit: the single clock; all state updates occur on its falling edge.
REQ-004 The block SHALL have port R, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port LD, input, 1 bit: load request, which qualifies DIN.
REQ-006 The block SHALL have port DIN, input, WIDTH bits: the parallel word to be serialised.
REQ-007 The block SHALL have port RDY, output, 1 bit: ready to accept a load.
REQ-008 The block SHALL have port SO, output, 1 bit: serial data driven to the D input of the first flop in the chain.
REQ-009 The block SHALL have port SE, output, 1 bit: shift enable for the flop chain, high for exactly one cycle per bit shifted.
REQ-010 The block SHALL have port BUSY, output, 1 bit: high while a transfer is in progress.
REQ-011 The block SHALL have port DONE, output, 1 bit: a one-cycle pulse when a transfer completes.

Function
REQ-012 The block SHALL implement a three-state FSM with states IDLE, SHIFT and FIN, encoded in 2 bits.
REQ-013 In IDLE, RDY SHALL be 1, and an accept SHALL occur on a CKN falling edge where LD=1 and RDY=1.
- On accept, the block captures DIN into the shift register, clears the counter and moves to SHIFT.
REQ-014 LD SHALL be ignored whenever RDY=0, with no queuing; DIN is sampled only at accept.
REQ-015 In SHIFT, the block SHALL assert SE=1 and BUSY=1, with SO equal to the shift register LSB.
- Each falling edge shifts the register right by one bit (MSB filled with 0) and increments the counter.
REQ-016 Bit order SHALL be LSB first, so DIN[0] appears on SO in the first SE cycle.
REQ-017 The block SHALL leave SHIFT after the final bit cycle, when the counter equals NBITS-1, and enter FIN.
- NBITS is defined in REQ-024.
REQ-018 In FIN, the block SHALL hold SE=0, BUSY=0 and DONE=1 for exactly one cycle, then return to IDLE.
REQ-019 Latency SHALL be NBITS+2 cycles from the accept edge to the DONE pulse, counting the FIN cycle.
- The earliest next accept is the edge after DONE.
REQ-020 Outside SHIFT, SE SHALL be 0 and SO SHALL be 0; the chain is never clocked spuriously.
REQ-021 If LD=1 in the same cycle as DONE, it SHALL be ignored, because RDY=0 in FIN.
REQ-022 Reserved state encoding 2'b11 SHALL be treated as illegal and return the FSM to IDLE on the next edge, with all outputs at idle values.

Reset
REQ-023 When R=1 on a CKN falling edge, the FSM SHALL go to IDLE and the shift register and counter SHALL clear to 0.
- Resulting outputs: RDY=1, SO=0, SE=0, BUSY=0, DONE=0.
- Reset overrides LD and any in-flight transfer; an aborted transfer produces no DONE.

Configuration
REQ-024 The macro BAN_SHIFT_PARITY_EN SHALL control parity generation.
- When defined, the block appends one even-parity bit (XOR of DIN captured at accept) after DIN[WIDTH-1], so NBITS=WIDTH+1 and the shift register is WIDTH+1 bits.
- When undefined, NBITS=WIDTH and no parity logic exists.
- Ports are identical in both builds.

Verification
REQ-025 Reset: hold R=1 for 2 cycles with LD=1 -> RDY=1, SE=0, SO=0, BUSY=0, DONE=0, and no accept occurs.
REQ-026 Basic load, WIDTH=8, parity off, LD pulse with DIN=8'hA5 -> SO=1,0,1,0,0,1,0,1 over 8 SE cycles, then DONE on cycle 10 after accept.
REQ-027 Parity on, DIN=8'h07 -> 9 SE cycles with the 9th SO=1 (odd popcount 3), then DONE at cycle 11.
REQ-028 Busy lockout: LD held high continuously with DIN changing each cycle -> a single transfer of the accepted word, the next accept on the edge after DONE, and back-to-back transfers spaced exactly NBITS+2 cycles apart.
REQ-029 Reset mid-shift: R=1 during the 4th SE cycle -> next edge gives IDLE, SE=0, no DONE, and a fresh LD with DIN=8'hFF then shifts 8 ones.
REQ-030 Illegal state: force the state register to 2'b11 -> next edge gives IDLE with RDY=1, SE=0 and DONE=0.
